mem_port_arbiter: RTL

- Shares one single-ported unified memory between the CPU's instruction-fetch requester (IF) and data load/store requester (D).
- Sits between the CPU core and the memory model.
- Serialises accesses with one transaction outstanding at a time.
- Gives D priority, with a starvation guard for IF.
- Returns read data and a completion pulse to whichever requester owns the transaction.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/arb_prio_sel.sv | 34 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Width of the latency and starvation counters (legal limits are 1..15)
    localparam int CNT_W = 4;

    // Bit positions inside the grant vector produced by arb_prio_sel
    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : arb_prio_sel
// Description : Combinational winner selection. D has priority unless IF
//               has lost STARVE_LIMIT consecutive arbitrations.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       gnt_vec
);

    logic w_if_starved;

    assign w_if_starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // At most one bit of the grant vector is ever set
    always_comb begin
        gnt_vec = 2'b00;
        if (if_req && (!d_req || w_if_starved)) begin
            gnt_vec[GNT_IF] = 1'b1;
        end else if (d_req) begin
            gnt_vec[GNT_D] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch
//               (IF) and data (D) requesters, one transaction in flight.
//               Optional macro ARB_PERF_CNT_EN adds grant/conflict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_gnt,
    output logic [31:0]       perf_d_gnt,
    output logic [31:0]       perf_conflict
`endif
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] STV_MAX  = CNT_W'(STARVE_LIMIT);

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [1:0]       w_gnt_vec;

    arb_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_sel (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (r_starve_cnt),
        .gnt_vec    (w_gnt_vec)
    );

    // Next state and all outputs; rst forces every output low combinationally
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        if_rdata    = '0;
        d_rdata     = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    if (w_gnt_vec[GNT_D]) begin
                        d_gnt       = 1'b1;
                        mem_en      = 1'b1;
                        mem_we      = d_we;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        w_state_nxt = ST_WAIT;
                    end else if (w_gnt_vec[GNT_IF]) begin
                        if_gnt      = 1'b1;
                        mem_en      = 1'b1;
                        mem_addr    = if_addr;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    if (r_owner == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transaction state: FSM, owner and remaining memory latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_D;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (d_gnt) begin
                r_owner   <= OWN_D;
                r_lat_cnt <= LAT_INIT;
            end else if (if_gnt) begin
                r_owner   <= OWN_IF;
                r_lat_cnt <= LAT_INIT;
            end else if (r_state == ST_WAIT && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    // Consecutive IF losses to D, saturating at the starvation limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (if_gnt) begin
            r_starve_cnt <= '0;
        end else if (d_gnt && if_req && r_starve_cnt != STV_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic w_conflict;

    // A cycle counts once if any request is pending without its grant
    assign w_conflict = (if_req && !if_gnt) || (d_req && !d_gnt);

    // Free-running wrapping performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_gnt   <= '0;
            perf_d_gnt    <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_gnt)     perf_if_gnt   <= perf_if_gnt + 32'd1;
            if (d_gnt)      perf_d_gnt    <= perf_d_gnt + 32'd1;
            if (w_conflict) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
